// File: rtl/jogo_pkg.sv
// State encoding for the memory-game control FSM; shared with the top-level
// 7-segment debug decoder so db_estado codes stay in one place.
package jogo_pkg;

    localparam logic [3:0] ST_INICIAL           = 4'h0;
    localparam logic [3:0] ST_PREPARACAO        = 4'h1;
    localparam logic [3:0] ST_INICIO_EXIBICAO   = 4'h2;
    localparam logic [3:0] ST_LEDS_ON           = 4'h3;
    localparam logic [3:0] ST_LEDS_OFF          = 4'h4;
    localparam logic [3:0] ST_PROXIMO_LED       = 4'h5;
    localparam logic [3:0] ST_INICIO_JOGADAS    = 4'h6;
    localparam logic [3:0] ST_ESPERA            = 4'h7;
    localparam logic [3:0] ST_REGISTRA          = 4'h8;
    localparam logic [3:0] ST_COMPARACAO        = 4'h9;
    localparam logic [3:0] ST_PROXIMA_JOGADA    = 4'hA;
    localparam logic [3:0] ST_PROXIMA_SEQUENCIA = 4'hB;
    localparam logic [3:0] ST_FIM_ACERTOU       = 4'hC;
    localparam logic [3:0] ST_FIM_ERROU         = 4'hD;
    localparam logic [3:0] ST_FIM_TIMEOUT       = 4'hE;

    // True for the terminal states where iniciar is honoured again.
    function automatic logic is_fim(input logic [3:0] st);
        return (st == ST_FIM_ACERTOU) || (st == ST_FIM_ERROU) || (st == ST_FIM_TIMEOUT);
    endfunction

endpackage

// File: rtl/unidade_controle_jogo.sv
// Moore control FSM for the memory game, driving fluxo_dados.
// Optional JOGO_TIMEOUT_EN: a timeout while waiting for a play ends the game.
module unidade_controle_jogo
    import jogo_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       nivel,
    input  logic       jogadaIgualMemoria,
    input  logic       enderecoIgualSequencia,
    input  logic       tem_jogada,
    input  logic       fimS,
    input  logic       meioE,
    input  logic       fimLedsOn,
    input  logic       fimLedsOff,
    input  logic       timeout,
    output logic       zeraE,
    output logic       contaE,
    output logic       zeraS,
    output logic       contaS,
    output logic       zeraR,
    output logic       registraR,
    output logic       estado_espera,
    output logic       estado_ledsOn,
    output logic       estado_ledsOff,
    output logic       macro_exibicao,
    output logic       macro_jogadas,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       timeout_fim,
    output logic [3:0] db_estado
);

    logic [3:0] estado_q, estado_d;
    logic       nivel_q,  nivel_d;
    logic       ultima_rodada;
    logic       fim_valido;

    // Long game ends when the sequence counter hits 15, short game at address 7.
    assign ultima_rodada = nivel_q ? fimS : meioE;

`ifdef JOGO_TIMEOUT_EN
    assign fim_valido = is_fim(estado_q);
`else
    wire unused_timeout = timeout;
    assign fim_valido = (estado_q == ST_FIM_ACERTOU) || (estado_q == ST_FIM_ERROU);
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= ST_INICIAL;
            nivel_q  <= 1'b0;
        end else begin
            estado_q <= estado_d;
            nivel_q  <= nivel_d;
        end
    end

    always_comb begin
        estado_d = ST_INICIAL;
        nivel_d  = nivel_q;
        if (fim_valido) begin
            estado_d = iniciar ? ST_PREPARACAO : estado_q;
        end else begin
            case (estado_q)
                ST_INICIAL:           estado_d = iniciar ? ST_PREPARACAO : ST_INICIAL;
                ST_PREPARACAO: begin
                    estado_d = ST_INICIO_EXIBICAO;
                    nivel_d  = nivel;
                end
                ST_INICIO_EXIBICAO:   estado_d = ST_LEDS_ON;
                ST_LEDS_ON:           estado_d = fimLedsOn ? ST_LEDS_OFF : ST_LEDS_ON;
                ST_LEDS_OFF: begin
                    if (!fimLedsOff)
                        estado_d = ST_LEDS_OFF;
                    else if (enderecoIgualSequencia)
                        estado_d = ST_INICIO_JOGADAS;
                    else
                        estado_d = ST_PROXIMO_LED;
                end
                ST_PROXIMO_LED:       estado_d = ST_LEDS_ON;
                ST_INICIO_JOGADAS:    estado_d = ST_ESPERA;
                ST_ESPERA: begin
                    // A play arriving together with the timeout still counts.
                    if (tem_jogada)
                        estado_d = ST_REGISTRA;
`ifdef JOGO_TIMEOUT_EN
                    else if (timeout)
                        estado_d = ST_FIM_TIMEOUT;
`endif
                    else
                        estado_d = ST_ESPERA;
                end
                ST_REGISTRA:          estado_d = ST_COMPARACAO;
                ST_COMPARACAO: begin
                    if (!jogadaIgualMemoria)
                        estado_d = ST_FIM_ERROU;
                    else if (!enderecoIgualSequencia)
                        estado_d = ST_PROXIMA_JOGADA;
                    else if (ultima_rodada)
                        estado_d = ST_FIM_ACERTOU;
                    else
                        estado_d = ST_PROXIMA_SEQUENCIA;
                end
                ST_PROXIMA_JOGADA:    estado_d = ST_ESPERA;
                ST_PROXIMA_SEQUENCIA: estado_d = ST_INICIO_EXIBICAO;
                default:              estado_d = ST_INICIAL;
            endcase
        end
    end

    always_comb begin
        zeraE          = 1'b0;
        contaE         = 1'b0;
        zeraS          = 1'b0;
        contaS         = 1'b0;
        zeraR          = 1'b0;
        registraR      = 1'b0;
        estado_espera  = 1'b0;
        estado_ledsOn  = 1'b0;
        estado_ledsOff = 1'b0;
        macro_exibicao = 1'b0;
        macro_jogadas  = 1'b0;
        pronto         = 1'b0;
        acertou        = 1'b0;
        errou          = 1'b0;
        timeout_fim    = 1'b0;
        case (estado_q)
            ST_PREPARACAO: begin
                zeraE = 1'b1;
                zeraS = 1'b1;
                zeraR = 1'b1;
            end
            ST_INICIO_EXIBICAO: begin
                zeraE          = 1'b1;
                zeraR          = 1'b1;
                macro_exibicao = 1'b1;
            end
            ST_LEDS_ON: begin
                estado_ledsOn  = 1'b1;
                macro_exibicao = 1'b1;
            end
            ST_LEDS_OFF: begin
                estado_ledsOff = 1'b1;
                macro_exibicao = 1'b1;
            end
            ST_PROXIMO_LED: begin
                contaE         = 1'b1;
                macro_exibicao = 1'b1;
            end
            ST_INICIO_JOGADAS: begin
                zeraE         = 1'b1;
                zeraR         = 1'b1;
                macro_jogadas = 1'b1;
            end
            ST_ESPERA: begin
                estado_espera = 1'b1;
                macro_jogadas = 1'b1;
            end
            ST_REGISTRA: begin
                registraR     = 1'b1;
                macro_jogadas = 1'b1;
            end
            ST_COMPARACAO:     macro_jogadas = 1'b1;
            ST_PROXIMA_JOGADA: begin
                contaE        = 1'b1;
                macro_jogadas = 1'b1;
            end
            ST_PROXIMA_SEQUENCIA: contaS = 1'b1;
            ST_FIM_ACERTOU: begin
                pronto  = 1'b1;
                acertou = 1'b1;
            end
            ST_FIM_ERROU: begin
                pronto = 1'b1;
                errou  = 1'b1;
            end
`ifdef JOGO_TIMEOUT_EN
            ST_FIM_TIMEOUT: begin
                pronto      = 1'b1;
                timeout_fim = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign db_estado = estado_q;

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// Scoreboard bench for unidade_controle_jogo: stimulus pushes the expected state
// per cycle, a negedge monitor pops and checks state code and all control outputs.
module tb_unidade_controle_jogo;

    logic clock = 1'b0;
    logic reset, iniciar, nivel, jig, eis, tem, fimS, meioE, fLOn, fLOff, tmo;
    logic zeraE, contaE, zeraS, contaS, zeraR, registraR;
    logic estado_espera, estado_ledsOn, estado_ledsOff, macro_exibicao, macro_jogadas;
    logic pronto, acertou, errou, timeout_fim;
    logic [3:0] db_estado;

    always #5 clock = ~clock;

    unidade_controle_jogo dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .nivel(nivel),
        .jogadaIgualMemoria(jig), .enderecoIgualSequencia(eis), .tem_jogada(tem),
        .fimS(fimS), .meioE(meioE), .fimLedsOn(fLOn), .fimLedsOff(fLOff), .timeout(tmo),
        .zeraE(zeraE), .contaE(contaE), .zeraS(zeraS), .contaS(contaS), .zeraR(zeraR),
        .registraR(registraR), .estado_espera(estado_espera), .estado_ledsOn(estado_ledsOn),
        .estado_ledsOff(estado_ledsOff), .macro_exibicao(macro_exibicao),
        .macro_jogadas(macro_jogadas), .pronto(pronto), .acertou(acertou), .errou(errou),
        .timeout_fim(timeout_fim), .db_estado(db_estado)
    );

    logic [3:0] sb[$];
    int nvec = 0;
    int nerr = 0;

    // Expected control word per state, bit order:
    // zeraE contaE zeraS contaS zeraR registraR espera ledsOn ledsOff mex mj pronto acertou errou timeout_fim
    function automatic logic [14:0] exp_outs(input logic [3:0] st);
        case (st)
            4'h1: return 15'b101010000000000;
            4'h2: return 15'b100010000100000;
            4'h3: return 15'b000000010100000;
            4'h4: return 15'b000000001100000;
            4'h5: return 15'b010000000100000;
            4'h6: return 15'b100010000010000;
            4'h7: return 15'b000000100010000;
            4'h8: return 15'b000001000010000;
            4'h9: return 15'b000000000010000;
            4'hA: return 15'b010000000010000;
            4'hB: return 15'b000100000000000;
            4'hC: return 15'b000000000001100;
            4'hD: return 15'b000000000001010;
            4'hE: return 15'b000000000001001;
            default: return 15'b0;
        endcase
    endfunction

    always @(negedge clock) begin
        if (sb.size() > 0) begin
            logic [3:0]  e;
            logic [14:0] act;
            e   = sb.pop_front();
            act = {zeraE, contaE, zeraS, contaS, zeraR, registraR, estado_espera,
                   estado_ledsOn, estado_ledsOff, macro_exibicao, macro_jogadas,
                   pronto, acertou, errou, timeout_fim};
            nvec++;
            if (db_estado !== e || act !== exp_outs(e)) begin
                nerr++;
                $display("FAIL state_outs vec %0d: got state %h outs %b, want state %h outs %b",
                         nvec, db_estado, act, e, exp_outs(e));
            end
        end
    end

    // Queue the state expected now, let the edge happen, then drop all pulse inputs.
    task automatic tick(input logic [3:0] exp);
        sb.push_back(exp);
        @(posedge clock);
        #1;
        {iniciar, jig, eis, tem, fimS, meioE, fLOn, fLOff, tmo} = '0;
    endtask

    // Full game from state 'start'. fail_r/fail_j select a wrong play (-1: none).
    // both_r: round whose first play arrives together with timeout.
    task automatic run_game(input logic lvl, input logic [3:0] start,
                            input int fail_r, input int fail_j, input int both_r);
        int last;
        last    = lvl ? 15 : 7;
        nivel   = lvl;
        iniciar = 1'b1;
        tick(start);
        tick(4'h1);
        nivel = ~lvl;               // must be ignored after preparacao
        for (int r = 0; r <= last; r++) begin
            tick(4'h2);
            for (int i = 0; i <= r; i++) begin
                fLOn = 1'b1;  tick(4'h3);
                fLOff = 1'b1; eis = (i == r); tick(4'h4);
                if (i != r) tick(4'h5);
            end
            tick(4'h6);
            for (int j = 0; j <= r; j++) begin
                tem = 1'b1;
                if (r == both_r && j == 0) tmo = 1'b1;
                tick(4'h7);
                tick(4'h8);
                jig   = !(r == fail_r && j == fail_j);
                eis   = (j == r);
                meioE = (j == 7);
                fimS  = (r == 15);
                tick(4'h9);
                if (r == fail_r && j == fail_j) begin
                    tick(4'hD);
                    tick(4'hD);
                    return;
                end
                if (j != r) tick(4'hA);
            end
            if (r != last) tick(4'hB);
        end
        tick(4'hC);
        tick(4'hC);
    endtask

    initial begin
        {iniciar, nivel, jig, eis, tem, fimS, meioE, fLOn, fLOff, tmo} = '0;
        reset = 1'b1;
        @(posedge clock);
        #1;
        tick(4'h0);                 // still in reset
        reset = 1'b0;
        tick(4'h0);                 // idle without iniciar

        run_game(1'b0, 4'h0, -1, -1, 0);    // short game, play+timeout in round 0
        run_game(1'b1, 4'hC, -1, -1, -1);   // long game, 16 rounds
        run_game(1'b0, 4'hC, 1, 1, -1);     // round 2, second play wrong

        // Restart from fim_errou, then reset mid leds_on.
        iniciar = 1'b1; tick(4'hD);
        tick(4'h1);
        tick(4'h2);
        reset = 1'b1; tick(4'h3);
        tick(4'h0);
        reset = 1'b0; tick(4'h0);

        // Timeout while waiting for the first play.
        iniciar = 1'b1; tick(4'h0);
        tick(4'h1);
        tick(4'h2);
        fLOn = 1'b1; tick(4'h3);
        fLOff = 1'b1; eis = 1'b1; tick(4'h4);
        tick(4'h6);
        tmo = 1'b1; tick(4'h7);
`ifdef JOGO_TIMEOUT_EN
        tick(4'hE);
        tick(4'hE);
        iniciar = 1'b1; tick(4'hE);
        tick(4'h1);
`else
        tmo = 1'b1; iniciar = 1'b1; tick(4'h7);
        tick(4'h7);
        tem = 1'b1; tick(4'h7);
        tick(4'h8);
`endif
        @(negedge clock);
        @(negedge clock);
        if (sb.size() != 0) begin
            nerr++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
